driver: RTL and testbench
=========================

# driver

Streams a 1024-byte monochrome frame buffer to a KS0108-style 128×64 graphic LCD built from two 64-column controller chips. The block reads frame-buffer bytes over a synchronous-read memory port and drives the LCD parallel bus (DB, D/I, CS1/CS2, E, R/W, RST). It sits between the game's frame-buffer RAM and the LCD pins. A start request triggers one full-screen refresh.

## Interface
- Reset: one clock; reset is asynchronous and active-high.
- `E_CYCLES`, default 4: clocks E is held high, and then low, per bus write.
- `RST_CYCLES`, default 8: clocks `rst_o` is held low after reset release.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  refresh request; level or pulse; latched.
- `addr_o`  out  10  frame-buffer byte address = {page[2:0], col[6:0]}.
- `data_i`  in  8  frame-buffer byte; valid the cycle after `addr_o` changes (1-cycle synchronous read).
- `db_o`  out  8  LCD data bus.
- `dori_o`  out  1  LCD D/I: 0 = instruction, 1 = display data.
- `cs_o`  out  2  chip selects, active-high. Bit 0 = left chip (cols 0–63); bit 1 = right chip (cols 64–127).
- `en_o`  out  1  LCD E strobe; data is latched by the LCD on the falling edge.
- `rw_o`  out  1  LCD R/W; constant 0 (write-only, no busy polling).
- `rst_o`  out  1  LCD reset, active-low.

## Operation
- Reset values: `rst_o`=0, `en_o`=0, `cs_o`=00, `dori_o`=0, `db_o`=0, `addr_o`=0, `rw_o`=0, pending flag clear.
- FSM states: RST_HOLD → IDLE → INIT_ON → INIT_LINE → SET_PAGE → SET_Y → DATA → (next chip / next page) → IDLE.
- RST_HOLD:
  - Count `RST_CYCLES`, then set `rst_o`=1 and go to IDLE.
  - A `start_i` seen in this state sets the pending flag.
- Pending flag:
  - Set by `start_i`=1 in any state.
  - Cleared when IDLE launches a frame.
  - A request arriving mid-frame causes exactly one further frame.
- IDLE: with pending set, enter INIT_ON.
- INIT_ON: write instruction 0x3F (display on) with `cs_o`=11.
- INIT_LINE: write instruction 0xC0 (start line 0) with `cs_o`=11.
- Per page p = 0..7, per chip c = 0..1, with `cs_o` one-hot for chip c:
  - SET_PAGE: instruction 0xB8|p.
  - SET_Y: instruction 0x40.
  - DATA: 64 data writes, y = 0..63, `addr_o` = p·128 + c·64 + y.
  - The chip's internal Y auto-increments.
- After page 7, chip 1: return to IDLE with `cs_o`=00, `en_o`=0.
- Frame total: 2 + 16·66 = 1058 bus writes.
- Byte bit 0 is the top pixel row of the page.

## Timing
- Every bus write (instruction or data) is exactly 2 + 2·`E_CYCLES` clocks (default 10):
  - Phase A, 1 clk: drive `addr_o` (data writes), `cs_o`, `dori_o`; `en_o`=0.
  - Phase B, 1 clk: register `db_o` (`data_i` for data writes, command byte otherwise); `en_o`=0.
  - Phase C, `E_CYCLES` clks: `en_o`=1.
  - Phase D, `E_CYCLES` clks: `en_o`=0.
- `db_o`, `cs_o`, `dori_o` are stable from phase B through the end of phase D.
- Writes are back-to-back; the next phase A follows the previous phase D directly.
- Start latency: the first `en_o` rise occurs 3 clocks after the clock at which IDLE sees pending set.
- Frame duration at defaults: 10580 clocks.
- Reset asserted mid-frame: all outputs return to reset values immediately; `rst_o` goes low; RST_HOLD restarts; pending is cleared.
- `start_i` during RST_HOLD: not lost; the frame starts after `rst_o` rises.

## Structure
- Package `driver_pkg` holds:
  - Command constants: CMD_DISP_ON=8'h3F, CMD_START_LINE=8'hC0, CMD_SET_PAGE=8'hB8, CMD_SET_Y=8'h40.
  - FSM state enum.
  - Write-phase enum.
- Sub-module `lcd_write_phy`:
  - Accepts a write request (byte source select, D/I, CS).
  - Sequences phases A–D and returns `done`.
  - The top-level FSM owns page/chip/y counters and addressing.

## Test plan
- Reset release: `rst_o`=0 for 8 clocks, then 1; all other outputs at reset values; no `en_o` pulse while idle.
- 5-clock `start_i` pulse with memory returning `data_i`=addr[7:0]:
  - First two writes: `db_o`=3F, then C0, with `cs_o`=11 and `dori_o`=0.
  - Next: B8, 40 with `cs_o`=01.
  - Then data 00..3F with `dori_o`=1.
- Chip switch and page increment:
  - After 64 data writes, `cs_o`=10, commands B8, 40, then data 40..7F.
  - Page 1 begins with B9 and reads addr 128.
- Frame end: exactly 1058 `en_o` pulses; each high 4 clks, low 4 clks; last data write uses addr 1023; then IDLE with `cs_o`=00.
- `start_i` pulse mid-frame: exactly one additional frame follows immediately after the current one.
- Reset asserted during DATA: outputs return to reset values asynchronously; the next `start_i` produces a frame beginning with 3F.

Source files
------------

// File: rtl/driver_pkg.sv
// Shared constants and types for the KS0108 frame-buffer driver.
package driver_pkg;

   localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
   localparam logic [7:0] CMD_START_LINE = 8'hC0;
   localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
   localparam logic [7:0] CMD_SET_Y      = 8'h40;

   localparam logic [1:0] CS_NONE  = 2'b00;
   localparam logic [1:0] CS_LEFT  = 2'b01;
   localparam logic [1:0] CS_RIGHT = 2'b10;
   localparam logic [1:0] CS_BOTH  = 2'b11;

   // Top-level FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_RST_HOLD  = 3'd0;
   localparam state_t ST_IDLE      = 3'd1;
   localparam state_t ST_INIT_ON   = 3'd2;
   localparam state_t ST_INIT_LINE = 3'd3;
   localparam state_t ST_SET_PAGE  = 3'd4;
   localparam state_t ST_SET_Y     = 3'd5;
   localparam state_t ST_DATA      = 3'd6;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_A    = 3'd1,
      PH_B    = 3'd2,
      PH_C    = 3'd3,
      PH_D    = 3'd4
   } phase_e;

endpackage

// File: rtl/driver_write_phy.sv
// Sequences one LCD bus write (setup, byte capture, E high, E low); takes the
// next request on the final E-low clock so writes run back-to-back.
module lcd_write_phy
   import driver_pkg::*;
#(
   parameter int E_CYCLES = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_i,
   input  logic       src_data_i,
   input  logic       dori_i,
   input  logic [1:0] cs_i,
   input  logic [7:0] cmd_i,
   input  logic [7:0] data_i,
   output logic       done_o,
   output logic [7:0] db_o,
   output logic       dori_o,
   output logic [1:0] cs_o,
   output logic       en_o
);

   localparam int CW = (E_CYCLES > 1) ? $clog2(E_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(E_CYCLES - 1);

   phase_e        ph_q, ph_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    db_q, db_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          src_q, src_d;
   logic          dori_q, dori_d;
   logic          en_q, en_d;
   logic [1:0]    cs_q, cs_d;

   assign done_o = (ph_q == PH_IDLE) || ((ph_q == PH_D) && (cnt_q == CNT_LAST));

   always_comb begin
      ph_d   = ph_q;
      cnt_d  = cnt_q;
      db_d   = db_q;
      cmd_d  = cmd_q;
      src_d  = src_q;
      dori_d = dori_q;
      en_d   = en_q;
      cs_d   = cs_q;
      case (ph_q)
         PH_IDLE: ;
         PH_A: ph_d = PH_B;
         PH_B: begin
            // Read data arrives during B, one clock after the address was issued
            db_d  = src_q ? data_i : cmd_q;
            en_d  = 1'b1;
            cnt_d = '0;
            ph_d  = PH_C;
         end
         PH_C: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               en_d  = 1'b0;
               cnt_d = '0;
               ph_d  = PH_D;
            end
         end
         PH_D: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cs_d   = CS_NONE;
               dori_d = 1'b0;
               cnt_d  = '0;
               ph_d   = PH_IDLE;
            end
         end
         default: ph_d = PH_IDLE;
      endcase
      if (req_i && done_o) begin
         ph_d   = PH_A;
         cnt_d  = '0;
         cs_d   = cs_i;
         dori_d = dori_i;
         src_d  = src_data_i;
         cmd_d  = cmd_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q   <= PH_IDLE;
         cnt_q  <= '0;
         db_q   <= '0;
         cmd_q  <= '0;
         src_q  <= 1'b0;
         dori_q <= 1'b0;
         en_q   <= 1'b0;
         cs_q   <= CS_NONE;
      end else begin
         ph_q   <= ph_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         cmd_q  <= cmd_d;
         src_q  <= src_d;
         dori_q <= dori_d;
         en_q   <= en_d;
         cs_q   <= cs_d;
      end
   end

   assign db_o   = db_q;
   assign dori_o = dori_q;
   assign cs_o   = cs_q;
   assign en_o   = en_q;

endmodule

// File: rtl/driver.sv
// Full-screen refresh of a two-chip 128x64 KS0108 panel from a 1 KiB frame buffer.
// Owns reset hold, refresh request latch, page/chip/column sequencing and addressing.
module driver
   import driver_pkg::*;
#(
   parameter int E_CYCLES   = 4,
   parameter int RST_CYCLES = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   output logic [9:0] addr_o,
   input  logic [7:0] data_i,
   output logic [7:0] db_o,
   output logic       dori_o,
   output logic [1:0] cs_o,
   output logic       en_o,
   output logic       rw_o,
   output logic       rst_o
);

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

   state_t         state_q, state_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   logic           pend_q, pend_d;
   logic [2:0]     page_q, page_d;
   logic           chip_q, chip_d;
   logic [5:0]     y_q, y_d;
   logic [9:0]     addr_q, addr_d;
   logic           lcd_rst_q, lcd_rst_d;

   logic       wr_req, wr_src, wr_dori, phy_done, issue;
   logic [1:0] wr_cs, chip_cs;
   logic [7:0] wr_cmd;

   assign chip_cs = chip_q ? CS_RIGHT : CS_LEFT;
   assign issue   = wr_req && phy_done;

   always_comb begin
      wr_req  = 1'b0;
      wr_src  = 1'b0;
      wr_dori = 1'b0;
      wr_cs   = CS_BOTH;
      wr_cmd  = CMD_DISP_ON;
      case (state_q)
         ST_INIT_ON:   wr_req = 1'b1;
         ST_INIT_LINE: begin
            wr_req = 1'b1;
            wr_cmd = CMD_START_LINE;
         end
         ST_SET_PAGE: begin
            wr_req = 1'b1;
            wr_cs  = chip_cs;
            wr_cmd = CMD_SET_PAGE | {5'b0, page_q};
         end
         ST_SET_Y: begin
            wr_req = 1'b1;
            wr_cs  = chip_cs;
            wr_cmd = CMD_SET_Y;
         end
         ST_DATA: begin
            wr_req  = 1'b1;
            wr_src  = 1'b1;
            wr_dori = 1'b1;
            wr_cs   = chip_cs;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      pend_d    = pend_q | start_i;
      page_d    = page_q;
      chip_d    = chip_q;
      y_d       = y_q;
      addr_d    = addr_q;
      lcd_rst_d = lcd_rst_q;
      case (state_q)
         ST_RST_HOLD: begin
            if (rcnt_q == RST_LAST) begin
               lcd_rst_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (pend_q) begin
               // A request coinciding with the launch still counts as a new one
               pend_d  = start_i;
               page_d  = '0;
               chip_d  = 1'b0;
               y_d     = '0;
               state_d = ST_INIT_ON;
            end
         end
         ST_INIT_ON:   if (issue) state_d = ST_INIT_LINE;
         ST_INIT_LINE: if (issue) state_d = ST_SET_PAGE;
         ST_SET_PAGE:  if (issue) state_d = ST_SET_Y;
         ST_SET_Y: begin
            if (issue) begin
               y_d     = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (issue) begin
               addr_d = {page_q, chip_q, y_q};
               y_d    = y_q + 1'b1;
               if (y_q == 6'd63) begin
                  chip_d  = ~chip_q;
                  state_d = ST_SET_PAGE;
                  if (chip_q) begin
                     if (page_q == 3'd7) state_d = ST_IDLE;
                     else                page_d  = page_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RST_HOLD;
         rcnt_q    <= '0;
         pend_q    <= 1'b0;
         page_q    <= '0;
         chip_q    <= 1'b0;
         y_q       <= '0;
         addr_q    <= '0;
         lcd_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         pend_q    <= pend_d;
         page_q    <= page_d;
         chip_q    <= chip_d;
         y_q       <= y_d;
         addr_q    <= addr_d;
         lcd_rst_q <= lcd_rst_d;
      end
   end

   lcd_write_phy #(
      .E_CYCLES (E_CYCLES)
   ) u_phy (
      .clk        (clk),
      .rst        (rst),
      .req_i      (wr_req),
      .src_data_i (wr_src),
      .dori_i     (wr_dori),
      .cs_i       (wr_cs),
      .cmd_i      (wr_cmd),
      .data_i     (data_i),
      .done_o     (phy_done),
      .db_o       (db_o),
      .dori_o     (dori_o),
      .cs_o       (cs_o),
      .en_o       (en_o)
   );

   assign addr_o = addr_q;
   assign rst_o  = lcd_rst_q;
   assign rw_o   = 1'b0;

endmodule

// File: tb/tb_driver.sv
// Directed/randomised bench for driver: a bus monitor records every E pulse and
// the initial block compares them to frames built from the panel's write rules.
module tb_driver;

   localparam int E  = 4;
   localparam int NW = 1058;

   typedef struct packed {
      logic [7:0] db;
      logic [1:0] cs;
      logic       dori;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic [9:0] addr_o;
   logic [7:0] data_i = 8'h00;
   logic [7:0] db_o;
   logic       dori_o;
   logic [1:0] cs_o;
   logic       en_o;
   logic       rw_o;
   logic       rst_o;

   logic [7:0] mem [1024];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;

   wr_t obs_q [$];
   int  hi_q  [$];
   int  gap_q [$];
   int  rise_q[$];

   driver #(.E_CYCLES(E), .RST_CYCLES(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .addr_o  (addr_o),
      .data_i  (data_i),
      .db_o    (db_o),
      .dori_o  (dori_o),
      .cs_o    (cs_o),
      .en_o    (en_o),
      .rw_o    (rw_o),
      .rst_o   (rst_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) data_i <= mem[addr_o];

   // Bus monitor: one record per E pulse, values taken while E is high
   logic prev_en = 1'b0;
   int   hi_run  = 0;
   int   lo_run  = 0;
   wr_t  cur;
   always @(negedge clk) begin
      if (en_o) begin
         if (!prev_en) begin
            gap_q.push_back(lo_run);
            rise_q.push_back(cyc);
         end
         hi_run = hi_run + 1;
         cur = '{db: db_o, cs: cs_o, dori: dori_o};
      end else begin
         if (prev_en) begin
            obs_q.push_back(cur);
            hi_q.push_back(hi_run);
            hi_run = 0;
            lo_run = 0;
         end
         lo_run = lo_run + 1;
      end
      prev_en = en_o;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want)
      else begin
         bad++;
         $error("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rst_o"},  32'(rst_o),  32'd0);
      chk({tag, "_en_o"},   32'(en_o),   32'd0);
      chk({tag, "_cs_o"},   32'(cs_o),   32'd0);
      chk({tag, "_dori_o"}, 32'(dori_o), 32'd0);
      chk({tag, "_db_o"},   32'(db_o),   32'd0);
      chk({tag, "_addr_o"}, 32'(addr_o), 32'd0);
      chk({tag, "_rw_o"},   32'(rw_o),   32'd0);
   endtask

   task automatic chk_wr(input string tag, input int k, input logic [7:0] db,
                         input logic [1:0] cs, input logic dori);
      wr_t w;
      w = (base + k < obs_q.size()) ? obs_q[base + k] : '1;
      chk({tag, "_db"},   32'(w.db),   32'(db));
      chk({tag, "_cs"},   32'(w.cs),   32'(cs));
      chk({tag, "_dori"}, 32'(w.dori), 32'(dori));
   endtask

   task automatic pulse_start(input int n, output int s);
      @(negedge clk);
      start_i = 1'b1;
      s = cyc;
      repeat (n) @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int i = 0;
      while ((obs_q.size() - base < n) && (i < budget)) begin
         @(posedge clk);
         i++;
      end
      repeat (60) @(posedge clk);
   endtask

   // Reference frame: 3F, C0, then per page/chip B8|p, 40 and 64 bytes
   task automatic check_batch(input string tag, input int nfr);
      wr_t exp_q [$];
      int  got_n, nbad, fb, nhi, ngap;
      for (int f = 0; f < nfr; f++) begin
         exp_q.push_back('{db: 8'h3F, cs: 2'b11, dori: 1'b0});
         exp_q.push_back('{db: 8'hC0, cs: 2'b11, dori: 1'b0});
         for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 2; c++) begin
               exp_q.push_back('{db: 8'(8'hB8 + p), cs: 2'(1 << c), dori: 1'b0});
               exp_q.push_back('{db: 8'h40, cs: 2'(1 << c), dori: 1'b0});
               for (int y = 0; y < 64; y++)
                  exp_q.push_back('{db: mem[p * 128 + c * 64 + y], cs: 2'(1 << c), dori: 1'b1});
            end
         end
      end
      got_n = obs_q.size() - base;
      chk({tag, "_write_count"}, 32'(got_n), 32'(exp_q.size()));
      nbad = 0; fb = -1; nhi = 0; ngap = 0;
      for (int k = 0; k < exp_q.size() && k < got_n; k++) begin
         if (obs_q[base + k] !== exp_q[k]) begin
            nbad++;
            if (fb < 0) fb = k;
         end
         if (hi_q[base + k] != E) nhi++;
         if (k > 0 && gap_q[base + k] != E + 2) ngap++;
      end
      chk($sformatf("%s_write_content_first_bad=%0d", tag, fb), 32'(nbad), 32'd0);
      chk({tag, "_e_high_len"}, 32'(nhi), 32'd0);
      chk({tag, "_e_low_gap"}, 32'(ngap), 32'd0);
      chk({tag, "_idle_cs"}, 32'(cs_o), 32'd0);
      chk({tag, "_idle_en"}, 32'(en_o), 32'd0);
      chk({tag, "_last_addr"}, 32'(addr_o), 32'd1023);
   endtask

   initial begin
      int s, n_en, sz;

      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

      // Reset and LCD reset hold
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_hold_%0d", n), 32'(rst_o), 32'(n >= 8));
      end
      n_en = 0;
      repeat (30) begin
         @(negedge clk);
         if (en_o || cs_o != 2'b00) n_en++;
      end
      chk("idle_quiet", 32'(n_en), 32'd0);

      // Single-clock request, address-pattern memory
      base = obs_q.size();
      pulse_start(1, s);
      wait_writes(NW, NW * 10 + 200);
      chk("start_latency", 32'((base < rise_q.size()) ? rise_q[base] - s : -1), 32'd5);
      check_batch("f1", 1);
      chk_wr("w0", 0, 8'h3F, 2'b11, 1'b0);
      chk_wr("w1", 1, 8'hC0, 2'b11, 1'b0);
      chk_wr("w2", 2, 8'hB8, 2'b01, 1'b0);
      chk_wr("w3", 3, 8'h40, 2'b01, 1'b0);
      chk_wr("w4", 4, 8'h00, 2'b01, 1'b1);
      chk_wr("w67", 67, 8'h3F, 2'b01, 1'b1);
      chk_wr("w68", 68, 8'hB8, 2'b10, 1'b0);
      chk_wr("w69", 69, 8'h40, 2'b10, 1'b0);
      chk_wr("w70", 70, 8'h40, 2'b10, 1'b1);
      chk_wr("w133", 133, 8'h7F, 2'b10, 1'b1);
      chk_wr("w134", 134, 8'hB9, 2'b01, 1'b0);
      chk_wr("w136", 136, 8'h80, 2'b01, 1'b1);
      chk_wr("w1057", 1057, 8'hFF, 2'b10, 1'b1);

      // 5-clock request: its tail outlasts the launch, so a second frame follows
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      base = obs_q.size();
      pulse_start(5, s);
      wait_writes(2 * NW, 2 * NW * 10 + 200);
      check_batch("f5clk", 2);

      // Request arriving mid-frame: exactly one more frame
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      base = obs_q.size();
      pulse_start(1, s);
      repeat ($urandom_range(200, 9000)) @(posedge clk);
      pulse_start(1, s);
      wait_writes(2 * NW, 2 * NW * 10 + 200);
      check_batch("fmid", 2);

      // Reset during DATA, with a request still pending
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      base = obs_q.size();
      pulse_start(5, s);
      sz = 5 + $urandom_range(0, 50);
      for (int i = 0; i < 2000 && (obs_q.size() - base < sz); i++) @(posedge clk);
      repeat ($urandom_range(0, 9)) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("mid_reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #1 chk("mid_rst_hold_low", 32'(rst_o), 32'd0);
      @(posedge clk);
      #1 chk("mid_rst_hold_high", 32'(rst_o), 32'd1);
      sz = obs_q.size();
      repeat (100) @(posedge clk);
      chk("pending_cleared", 32'(obs_q.size() - sz), 32'd0);
      base = obs_q.size();
      pulse_start(1, s);
      wait_writes(NW, NW * 10 + 200);
      check_batch("after_reset", 1);
      chk_wr("ar_w0", 0, 8'h3F, 2'b11, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
